dual_slope_counter: RTL and testbench
=====================================

# dual_slope_counter

- Counting datapath for the dual-slope ADC.
- Sits opposite the conversion-control FSM and consumes its switch-select vector `ch`:
  - During the input-integration phase it times the fixed integration window and returns the `en_3` pulse that moves the FSM to the reference phase.
  - During de-integration it counts clock cycles until the integrator zero-crossing `Vint_z`, then presents the count as the conversion result with a valid/ack handshake.

## Interface
Parameters:
- `N_INT`, default 1000: integration window length in clock cycles, ≥2.
- `WIDTH`, default 12: width of the de-integration counter and result.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ch`  in  3  switch select from the control FSM: bit0 ch_vm, bit1 ch_ref, bit2 ch_zr; one-hot.
- `Vint_z`  in  1  integrator zero-crossing, synchronous to `clk`.
- `result_ack`  in  1  consumer accepts `result`.
- `en_3`  out  1  end-of-integration pulse to the FSM.
- `result`  out  WIDTH  de-integration count.
- `result_valid`  out  1  `result` holds a completed conversion.
- `overrange`  out  1  the last conversion saturated.

## Operation
- States: IDLE, INTEG, DEINT, DONE.
- Reset values: state IDLE, internal counter 0, `en_3`=0, `result`=0, `result_valid`=0, `overrange`=0.
- IDLE:
  - Counter held at 0.
  - `ch`==3'b001 → INTEG.
- INTEG:
  - Counter increments every edge.
  - On the edge where the counter equals N_INT-1: `en_3` is set, the counter is cleared, and the state moves to DEINT.
  - `Vint_z` is ignored.
- DEINT:
  - While `ch`==3'b001 (FSM has not yet switched), the counter holds at 0. This is the grace window.
  - While `ch`==3'b010:
    - Edge with `Vint_z`=0: the counter increments.
    - Edge with `Vint_z`=1: `result` ← counter, `result_valid` ← 1, `overrange` ← 0, state → DONE.
- DONE:
  - `result` and `result_valid` are held until `result_ack` is sampled high.
  - On ack: `result_valid` ← 0 and state → IDLE.
  - `ch`==3'b001 in DONE without ack is ignored; the conversion is not started.
- Abort:
  - In INTEG or DEINT, any `ch` other than 3'b001/3'b010 (including 3'b100, 0, or multi-hot) returns the state to IDLE.
  - The counter is cleared.
  - `en_3` is not issued and `result`/`result_valid` are unchanged.
- `result_ack` outside DONE has no effect.
- Arithmetic: unsigned. The integration counter is sized ceil(log2(N_INT)) bits and is separate from the WIDTH-bit result counter.

## Timing
- `en_3` is a registered output, high for exactly one clock period per conversion. It starts at the edge that completes the N_INT-th INTEG cycle, so it is observed N_INT cycles after the first INTEG edge.
- The FSM samples `en_3` on the falling edge; the one-full-period pulse guarantees exactly one falling edge sees it.
- `result` equals the number of DEINT edges with `ch`==3'b010 and `Vint_z`=0 before the first `Vint_z`=1 edge.
  - `Vint_z` high on the first such edge yields 0.
- `result_valid` rises at the edge that samples `Vint_z`=1. There is no additional latency.
- Ack handshake:
  - `result_valid` falls at the edge sampling `result_ack`=1.
  - If `ch`==3'b001 at that same edge, the state goes to IDLE, and the next edge enters INTEG.
- Reset asserted at any time, including mid-INTEG or mid-DEINT, forces all outputs and state to their reset values immediately, independent of `clk`.

## Configuration
- Macro `DSC_OVERRANGE_EN`.
- Defined:
  - In DEINT, if the counter is at 2^WIDTH-1 and `Vint_z`=0 on an edge, the block sets `result`=2^WIDTH-1, `result_valid`=1, `overrange`=1, and moves to DONE.
  - `overrange` clears on the next valid conversion or on reset.
- Not defined:
  - No saturation check; the counter wraps modulo 2^WIDTH.
  - DEINT waits indefinitely for `Vint_z` or abort.
  - `overrange` is tied to 0.

## Test plan
- N_INT=8, reset released, `ch`=3'b001 held → `en_3` high for exactly one period, 8 cycles after the first INTEG edge; no second pulse.
- After `en_3`, keep `ch`=3'b001 for 2 cycles, then `ch`=3'b010, with `Vint_z` rising on the 6th edge → `result`=5, `result_valid`=1 until `result_ack` is pulsed, then 0 and state IDLE.
- WIDTH=4 with `DSC_OVERRANGE_EN`, `ch`=3'b010 and `Vint_z` never asserted → after 15 increments, `result`=15, `overrange`=1, `result_valid`=1. Without the macro, no `result_valid` after 40 cycles.
- `reset` pulsed mid-DEINT (counter at 3) → all outputs 0 immediately, state IDLE; a subsequent full conversion produces a correct result.
- `ch` switched to 3'b100 at INTEG cycle 4 (N_INT=8) → no `en_3`, no `result_valid`; `Vint_z` pulsed during INTEG is ignored.
- `result_valid` pending with `ch`=3'b001 and no ack for 10 cycles → no `en_3`. Ack with `ch`=3'b001 → `en_3` pulse N_INT+1 cycles after the ack edge.

Source files
------------

// File: rtl/dual_slope_counter_if.sv
// rtl/dual_slope_counter_if.sv - Signal bundle between the dual-slope control FSM and the counting datapath
interface dual_slope_counter_if #(
    parameter int WIDTH = 12
);
    logic [2:0]       ch;
    logic             Vint_z;
    logic             result_ack;
    logic             en_3;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             overrange;

    // Control FSM, comparator and result consumer side
    modport master (
        output ch, Vint_z, result_ack,
        input  en_3, result, result_valid, overrange
    );

    // Counting datapath side
    modport slave (
        input  ch, Vint_z, result_ack,
        output en_3, result, result_valid, overrange
    );
endinterface

// File: rtl/dual_slope_counter.sv
// rtl/dual_slope_counter.sv - Dual-slope ADC counting datapath (optional saturation via DSC_OVERRANGE_EN)
module dual_slope_counter #(
    parameter int N_INT = 1000,
    parameter int WIDTH = 12
) (
    input  logic                clk,
    input  logic                reset,
    dual_slope_counter_if.slave bus
);
    // Integration window counter only needs to reach N_INT-1
    localparam int              IW        = (N_INT > 1) ? $clog2(N_INT) : 1;
    localparam logic [IW-1:0]   ICNT_LAST = IW'(N_INT - 1);

    // Switch-select codes from the control FSM
    localparam logic [2:0] CH_VM  = 3'b001;
    localparam logic [2:0] CH_REF = 3'b010;

`ifdef DSC_OVERRANGE_EN
    localparam logic [WIDTH-1:0] DCNT_MAX = '1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        DEINT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    icnt_q, icnt_d;
    logic [WIDTH-1:0] dcnt_q, dcnt_d;
    logic             en3_q, en3_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
`ifdef DSC_OVERRANGE_EN
    logic             ovr_q, ovr_d;
`endif

    // Next-state and datapath decisions; en_3 is a one-period pulse so it defaults low
    always_comb begin
        state_d  = state_q;
        icnt_d   = icnt_q;
        dcnt_d   = dcnt_q;
        en3_d    = 1'b0;
        result_d = result_q;
        valid_d  = valid_q;
`ifdef DSC_OVERRANGE_EN
        ovr_d    = ovr_q;
`endif

        case (state_q)
            IDLE: begin
                icnt_d = '0;
                dcnt_d = '0;
                if (bus.ch == CH_VM) begin
                    state_d = INTEG;
                end
            end

            INTEG: begin
                // Vint_z is deliberately not looked at while integrating the input
                if (bus.ch == CH_VM || bus.ch == CH_REF) begin
                    if (icnt_q == ICNT_LAST) begin
                        en3_d   = 1'b1;
                        icnt_d  = '0;
                        dcnt_d  = '0;
                        state_d = DEINT;
                    end else begin
                        icnt_d = icnt_q + 1'b1;
                    end
                end else begin
                    icnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = IDLE;
                end
            end

            DEINT: begin
                // ch still at CH_VM is the grace window while the FSM reacts to en_3
                if (bus.ch == CH_REF) begin
                    if (bus.Vint_z) begin
                        result_d = dcnt_q;
                        valid_d  = 1'b1;
`ifdef DSC_OVERRANGE_EN
                        ovr_d    = 1'b0;
`endif
                        dcnt_d   = '0;
                        state_d  = DONE;
                    end
`ifdef DSC_OVERRANGE_EN
                    else if (dcnt_q == DCNT_MAX) begin
                        result_d = DCNT_MAX;
                        valid_d  = 1'b1;
                        ovr_d    = 1'b1;
                        dcnt_d   = '0;
                        state_d  = DONE;
                    end
`endif
                    else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end else if (bus.ch != CH_VM) begin
                    icnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = IDLE;
                end
            end

            DONE: begin
                // A new start request is ignored until the result has been taken
                if (bus.result_ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                icnt_d  = '0;
                dcnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            icnt_q   <= '0;
            dcnt_q   <= '0;
            en3_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
`ifdef DSC_OVERRANGE_EN
            ovr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            icnt_q   <= icnt_d;
            dcnt_q   <= dcnt_d;
            en3_q    <= en3_d;
            result_q <= result_d;
            valid_q  <= valid_d;
`ifdef DSC_OVERRANGE_EN
            ovr_q    <= ovr_d;
`endif
        end
    end

    assign bus.en_3         = en3_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
`ifdef DSC_OVERRANGE_EN
    assign bus.overrange    = ovr_q;
`else
    assign bus.overrange    = 1'b0;
`endif

endmodule

// File: tb/tb_dual_slope_counter.sv
// tb/tb_dual_slope_counter.sv - Randomized model-checked bench for dual_slope_counter
module tb_dual_slope_counter;
    localparam int N_INT = 8;
    localparam int WIDTH = 4;
    localparam int RMAX  = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dual_slope_counter_if #(.WIDTH(WIDTH)) bus ();

    dual_slope_counter #(.N_INT(N_INT), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion is "integrate N_INT edges, then count reference edges until zero-crossing"
    typedef enum {PH_IDLE, PH_INTEG, PH_DEINT, PH_DONE} phase_t;
    phase_t m_phase;
    int     m_integ_edges;
    int     m_ref_edges;
    bit     m_en3;
    int     m_result;
    bit     m_valid;
    bit     m_ovr;

    task automatic model_reset();
        m_phase       = PH_IDLE;
        m_integ_edges = 0;
        m_ref_edges   = 0;
        m_en3         = 1'b0;
        m_result      = 0;
        m_valid       = 1'b0;
        m_ovr         = 1'b0;
    endtask

    task automatic model_finish(input int value, input bit sat);
        m_result = value;
        m_valid  = 1'b1;
        m_ovr    = sat;
        m_phase  = PH_DONE;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
        end else begin
            m_en3 = 1'b0;
            case (m_phase)
                PH_IDLE: begin
                    if (bus.ch == 3'b001) begin
                        m_phase       = PH_INTEG;
                        m_integ_edges = 0;
                    end
                end
                PH_INTEG: begin
                    if (bus.ch inside {3'b001, 3'b010}) begin
                        m_integ_edges++;
                        if (m_integ_edges == N_INT) begin
                            m_en3       = 1'b1;
                            m_phase     = PH_DEINT;
                            m_ref_edges = 0;
                        end
                    end else begin
                        m_phase = PH_IDLE;
                    end
                end
                PH_DEINT: begin
                    if (bus.ch == 3'b010) begin
                        if (bus.Vint_z) begin
                            model_finish(m_ref_edges % (RMAX + 1), 1'b0);
                        end
`ifdef DSC_OVERRANGE_EN
                        else if (m_ref_edges == RMAX) begin
                            model_finish(RMAX, 1'b1);
                        end
`endif
                        else begin
                            m_ref_edges++;
                        end
                    end else if (bus.ch != 3'b001) begin
                        m_phase = PH_IDLE;
                    end
                end
                PH_DONE: begin
                    if (bus.result_ack) begin
                        m_valid = 1'b0;
                        m_phase = PH_IDLE;
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    // One clock: inputs applied in the low phase, model advanced at the edge, outputs read at negedge
    task automatic step(input logic [2:0] c, input logic vz, input logic ack);
        bus.ch         = c;
        bus.Vint_z     = vz;
        bus.result_ack = ack;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [2:0] bad_ch();
        case ($urandom_range(0, 5))
            0:       return 3'b000;
            1:       return 3'b100;
            2:       return 3'b011;
            3:       return 3'b101;
            4:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    // Asynchronous reset pulse inside the low phase, no clock edge involved
    task automatic async_reset_pulse(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check({tag, "_en_3"},         bus.en_3,         0);
        check({tag, "_result"},       bus.result,       0);
        check({tag, "_result_valid"}, bus.result_valid, 0);
        check({tag, "_overrange"},    bus.overrange,    0);
        #1;
        reset = 1'b0;
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_en_3",         bus.en_3,         m_en3);
            check("cyc_result",       bus.result,       m_result);
            check("cyc_result_valid", bus.result_valid, m_valid);
            check("cyc_overrange",    bus.overrange,    m_ovr);
        end
    end

    initial begin
        int first_en;
        int pulses;
        int valid_seen;
        int len;

        reset          = 1'b0;
        bus.ch         = 3'b000;
        bus.Vint_z     = 1'b0;
        bus.result_ack = 1'b0;
        model_reset();

        async_reset_pulse("reset");
        chk_on = 1'b1;
        step(3'b000, 1'b0, 1'b0);

        // en_3 timing with ch held at 3'b001, then a result of 5
        first_en = -1;
        pulses   = 0;
        step(3'b001, 1'b0, 1'b0);
        for (int i = 1; i <= N_INT + 2; i++) begin
            step(3'b001, rbit(), 1'b0);
            if (bus.en_3) begin
                pulses++;
                if (first_en < 0) first_en = i;
            end
        end
        check("en3_first_edge", first_en, N_INT);
        check("en3_pulse_count", pulses, 1);
        repeat (5) step(3'b010, 1'b0, 1'b0);
        step(3'b010, 1'b1, 1'b0);
        check("conv5_result", bus.result, 5);
        check("conv5_valid", bus.result_valid, 1);
        repeat (3) step(3'b000, 1'b0, 1'b0);
        check("conv5_valid_held", bus.result_valid, 1);
        step(3'b000, 1'b0, 1'b1);
        check("conv5_valid_after_ack", bus.result_valid, 0);

        // Reset in the middle of de-integration, then a clean conversion of 7
        step(3'b001, 1'b0, 1'b0);
        repeat (N_INT) step(3'b001, 1'b0, 1'b0);
        repeat (3) step(3'b010, 1'b0, 1'b0);
        async_reset_pulse("midreset");
        step(3'b001, 1'b0, 1'b0);
        repeat (N_INT) step(3'b001, 1'b0, 1'b0);
        repeat (7) step(3'b010, 1'b0, 1'b0);
        step(3'b010, 1'b1, 1'b0);
        check("post_reset_result", bus.result, 7);
        step(3'b000, 1'b0, 1'b1);

        // Abort with 3'b100 at integration cycle 4; Vint_z toggled meanwhile
        pulses     = 0;
        valid_seen = 0;
        step(3'b001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(3'b001, 1'(i), 1'b0);
        step(3'b100, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(3'b000, 1'(i), 1'b0);
            if (bus.en_3) pulses++;
            if (bus.result_valid) valid_seen++;
        end
        check("abort_no_en3", pulses, 0);
        check("abort_no_valid", valid_seen, 0);

        // Vint_z never arrives
        step(3'b001, 1'b0, 1'b0);
        repeat (N_INT) step(3'b001, 1'b0, 1'b0);
        repeat (RMAX) step(3'b010, 1'b0, 1'b0);
        check("sat_not_yet_valid", bus.result_valid, 0);
        step(3'b010, 1'b0, 1'b0);
`ifdef DSC_OVERRANGE_EN
        check("sat_result", bus.result, RMAX);
        check("sat_valid", bus.result_valid, 1);
        check("sat_overrange", bus.overrange, 1);
        step(3'b000, 1'b0, 1'b1);
        step(3'b001, 1'b0, 1'b0);
        repeat (N_INT) step(3'b001, 1'b0, 1'b0);
        step(3'b010, 1'b1, 1'b0);
        check("zero_result", bus.result, 0);
        check("zero_clears_overrange", bus.overrange, 0);
        step(3'b000, 1'b0, 1'b1);
`else
        repeat (40 - RMAX - 1) step(3'b010, 1'b0, 1'b0);
        check("nosat_no_valid_40", bus.result_valid, 0);
        check("nosat_overrange", bus.overrange, 0);
        step(3'b100, 1'b0, 1'b0);
`endif

        // Pending result blocks a restart; ack with ch=001 restarts one cycle later
        step(3'b001, 1'b0, 1'b0);
        repeat (N_INT) step(3'b001, 1'b0, 1'b0);
        repeat (2) step(3'b010, 1'b0, 1'b0);
        step(3'b010, 1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(3'b001, rbit(), 1'b0);
            if (bus.en_3) pulses++;
        end
        check("pending_no_en3", pulses, 0);
        check("pending_valid_held", bus.result_valid, 1);
        step(3'b001, 1'b0, 1'b1);
        first_en = -1;
        for (int i = 1; i <= N_INT + 3; i++) begin
            step(3'b001, 1'b0, 1'b0);
            if (bus.en_3 && first_en < 0) first_en = i;
        end
        check("ack_restart_en3_edge", first_en, N_INT + 1);
        step(3'b100, 1'b0, 1'b0);

        // Randomized conversions with aborts, grace windows, noise on ack and Vint_z
        for (int c = 0; c < 40; c++) begin
            step(3'b001, rbit(), 1'b0);
            for (int i = 0; i < N_INT; i++) begin
                if ($urandom_range(0, 40) == 0) begin
                    step(bad_ch(), rbit(), rbit());
                    break;
                end
                step(3'b001, rbit(), rbit());
            end
            repeat ($urandom_range(0, 3)) step(3'b001, rbit(), 1'b0);
            len = $urandom_range(0, 20);
            for (int i = 0; i <= len; i++) begin
                if ($urandom_range(0, 60) == 0) begin
                    step(bad_ch(), rbit(), rbit());
                    break;
                end
                step(3'b010, (i == len), rbit());
            end
            repeat ($urandom_range(0, 4)) step(3'($urandom), rbit(), 1'b0);
            step(($urandom_range(0, 1) != 0) ? 3'b001 : 3'b000, rbit(), 1'b1);
            if ($urandom_range(0, 15) == 0) async_reset_pulse("rand_reset");
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
